// File: rtl/framewriter_pkg.sv
// Shared types and AXI constants for the framebuffer writer.
package framewriter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_ADDR      = 3'd2,
    ST_DATA      = 3'd3,
    ST_RESP      = 3'd4
  } fw_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  // Bufferable + modifiable: lets the interconnect merge/buffer framebuffer writes.
  localparam logic [3:0] AXI_AWCACHE    = 4'b0011;

endpackage

// File: rtl/framewriter_pixel_fifo.sv
// Pixel word FIFO; full/empty come from the registered occupancy count.
module pixel_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/framewriter.sv
// Streams one frame of pixel words into memory as fixed-length AXI4 INCR bursts.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   ST_IDLE      | no frame in progress; waiting for start_frame
//   ST_WAIT_DATA | collecting pixels until a full burst is buffered
//   ST_ADDR      | AWVALID high, waiting for AWREADY
//   ST_DATA      | streaming BURST_LEN beats from the FIFO
//   ST_RESP      | BREADY high, waiting for the write response
module framewriter
  import framewriter_pkg::*;
#(
  parameter int C_M_AXI_BURST_LEN    = 16,
  parameter int C_M_AXI_ID_WIDTH     = 1,
  parameter int C_M_AXI_ADDR_WIDTH   = 32,
  parameter int C_M_AXI_DATA_WIDTH   = 32,
  parameter int C_M_AXI_AWUSER_WIDTH = 0,
  parameter int C_M_AXI_WUSER_WIDTH  = 0,
  parameter int C_M_AXI_BUSER_WIDTH  = 0,
  parameter int FRAME_WORDS          = 153600
) (
  input  logic                                  M_AXI_ACLK,
  input  logic                                  M_AXI_ARESET,
  input  logic                                  start_frame,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]         base_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]         pixel_data,
  input  logic                                  pixel_valid,
  output logic                                  pixel_ready,
  output logic                                  busy,
  output logic                                  frame_done,
  output logic                                  bresp_err,
  output logic [C_M_AXI_ID_WIDTH-1:0]           M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]         M_AXI_AWADDR,
  output logic [7:0]                            M_AXI_AWLEN,
  output logic [2:0]                            M_AXI_AWSIZE,
  output logic [1:0]                            M_AXI_AWBURST,
  output logic                                  M_AXI_AWLOCK,
  output logic [3:0]                            M_AXI_AWCACHE,
  output logic [2:0]                            M_AXI_AWPROT,
  output logic [3:0]                            M_AXI_AWQOS,
  output logic [(C_M_AXI_AWUSER_WIDTH > 0 ? C_M_AXI_AWUSER_WIDTH : 1)-1:0] M_AXI_AWUSER,
  output logic                                  M_AXI_AWVALID,
  input  logic                                  M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]         M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]       M_AXI_WSTRB,
  output logic                                  M_AXI_WLAST,
  output logic [(C_M_AXI_WUSER_WIDTH > 0 ? C_M_AXI_WUSER_WIDTH : 1)-1:0] M_AXI_WUSER,
  output logic                                  M_AXI_WVALID,
  input  logic                                  M_AXI_WREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]           M_AXI_BID,
  input  logic [1:0]                            M_AXI_BRESP,
  input  logic [(C_M_AXI_BUSER_WIDTH > 0 ? C_M_AXI_BUSER_WIDTH : 1)-1:0] M_AXI_BUSER,
  input  logic                                  M_AXI_BVALID,
  output logic                                  M_AXI_BREADY
);

  localparam int BEAT_BYTES  = C_M_AXI_DATA_WIDTH / 8;
  localparam int BURST_BYTES = C_M_AXI_BURST_LEN * BEAT_BYTES;
  localparam int FIFO_DEPTH  = 2 * C_M_AXI_BURST_LEN;
  localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam int NUM_BURSTS  = FRAME_WORDS / C_M_AXI_BURST_LEN;
  localparam int WORD_W      = $clog2(FRAME_WORDS + 1);
  localparam int BURST_W     = $clog2(NUM_BURSTS + 1);
  localparam int BEAT_W      = $clog2(C_M_AXI_BURST_LEN);

  fw_state_t                     state;
  fw_state_t                     state_nxt;
  logic [WORD_W-1:0]             words_in;
  logic [BURST_W-1:0]            burst_idx;
  logic [BEAT_W-1:0]             beat;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [CNT_W-1:0]              fifo_count;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          start_acc;
  logic                          push;
  logic                          aw_hs;
  logic                          w_hs;
  logic                          b_hs;
  logic                          beat_last;
  logic                          last_burst;
  logic                          burst_ready;
  logic                          unused_inputs;

  assign start_acc   = start_frame && (state == ST_IDLE);
  assign push        = pixel_valid && pixel_ready;
  assign aw_hs       = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_hs        = M_AXI_WVALID && M_AXI_WREADY;
  assign b_hs        = M_AXI_BVALID && M_AXI_BREADY;
  assign beat_last   = (beat == BEAT_W'(C_M_AXI_BURST_LEN - 1));
  assign last_burst  = (burst_idx == BURST_W'(NUM_BURSTS - 1));
  assign burst_ready = (fifo_count >= CNT_W'(C_M_AXI_BURST_LEN));

  assign busy        = (state != ST_IDLE);
  assign pixel_ready = busy && !fifo_full && (words_in < WORD_W'(FRAME_WORDS));

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWLEN   = 8'(C_M_AXI_BURST_LEN - 1);
  assign M_AXI_AWSIZE  = 3'($clog2(BEAT_BYTES));
  assign M_AXI_AWBURST = AXI_BURST_INCR;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = AXI_AWCACHE;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'b0000;
  assign M_AXI_AWUSER  = '0;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WUSER   = '0;
  assign M_AXI_WLAST   = (state == ST_DATA) && beat_last;

  // Response ID/user carry nothing we act on: only one burst is ever outstanding.
  assign unused_inputs = ^{M_AXI_BID, M_AXI_BUSER, fifo_empty};

  pixel_fifo #(
    .WIDTH (C_M_AXI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (M_AXI_ACLK),
    .rst   (M_AXI_ARESET),
    .push  (push),
    .din   (pixel_data),
    .pop   (w_hs),
    .dout  (M_AXI_WDATA),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  // Next-state and channel valid/ready decode.
  always_comb begin
    state_nxt     = state;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_frame) state_nxt = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (burst_ready) state_nxt = ST_ADDR;
      end
      ST_ADDR: begin
        M_AXI_AWVALID = 1'b1;
        if (M_AXI_AWREADY) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        M_AXI_WVALID = 1'b1;
        if (M_AXI_WREADY && beat_last) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) state_nxt = last_burst ? ST_IDLE : ST_WAIT_DATA;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Frame bookkeeping: word/burst/beat counters, burst address, status flags.
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      words_in   <= '0;
      burst_idx  <= '0;
      beat       <= '0;
      addr_q     <= '0;
      bresp_err  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= b_hs && last_burst;
      if (start_acc) begin
        words_in  <= '0;
        burst_idx <= '0;
        beat      <= '0;
        addr_q    <= base_addr;
        bresp_err <= 1'b0;
      end else begin
        if (push)  words_in <= words_in + 1'b1;
        if (aw_hs) addr_q   <= addr_q + C_M_AXI_ADDR_WIDTH'(BURST_BYTES);
        if (w_hs)  beat     <= beat + 1'b1;
        if (b_hs) begin
          burst_idx <= burst_idx + 1'b1;
          if (M_AXI_BRESP != AXI_RESP_OKAY) bresp_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_framewriter.sv
// Directed bench for framewriter: BURST_LEN=16, FRAME_WORDS=32.
module tb_framewriter;

  localparam int BL = 16;
  localparam int FW = 32;

  logic        clk;
  logic        rst;
  logic        start_frame;
  logic [31:0] base_addr;
  logic [31:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        busy;
  logic        frame_done;
  logic        bresp_err;
  logic [0:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [3:0]  awqos;
  logic [0:0]  awuser;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic [0:0]  wuser;
  logic        wvalid;
  logic        wready;
  logic [0:0]  bid;
  logic [1:0]  bresp;
  logic [0:0]  buser;
  logic        bvalid;
  logic        bready;

  int total;
  int bad;

  framewriter #(
    .C_M_AXI_BURST_LEN (BL),
    .FRAME_WORDS       (FW)
  ) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESET  (rst),
    .start_frame   (start_frame),
    .base_addr     (base_addr),
    .pixel_data    (pixel_data),
    .pixel_valid   (pixel_valid),
    .pixel_ready   (pixel_ready),
    .busy          (busy),
    .frame_done    (frame_done),
    .bresp_err     (bresp_err),
    .M_AXI_AWID    (awid),
    .M_AXI_AWADDR  (awaddr),
    .M_AXI_AWLEN   (awlen),
    .M_AXI_AWSIZE  (awsize),
    .M_AXI_AWBURST (awburst),
    .M_AXI_AWLOCK  (awlock),
    .M_AXI_AWCACHE (awcache),
    .M_AXI_AWPROT  (awprot),
    .M_AXI_AWQOS   (awqos),
    .M_AXI_AWUSER  (awuser),
    .M_AXI_AWVALID (awvalid),
    .M_AXI_AWREADY (awready),
    .M_AXI_WDATA   (wdata),
    .M_AXI_WSTRB   (wstrb),
    .M_AXI_WLAST   (wlast),
    .M_AXI_WUSER   (wuser),
    .M_AXI_WVALID  (wvalid),
    .M_AXI_WREADY  (wready),
    .M_AXI_BID     (bid),
    .M_AXI_BRESP   (bresp),
    .M_AXI_BUSER   (buser),
    .M_AXI_BVALID  (bvalid),
    .M_AXI_BREADY  (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_pulse(input logic [31:0] base);
    @(negedge clk);
    base_addr   = base;
    start_frame = 1'b1;
    @(negedge clk);
    start_frame = 1'b0;
    base_addr   = 32'hDEAD_0000;
  endtask

  // Acts as pixel source and AXI slave for one frame; inputs change at negedge only.
  task automatic run_frame(input logic [31:0] base, input int gap, input int aw_delay,
                           input bit w_toggle, input int err_burst, input int offer);
    int cyc = 0, sent = 0, next_cyc = 0, aw_n = 0, w_n = 0, b_n = 0, dn = 0, tail = 0;
    int aw_wait = 0, last_b_cyc = 0, done_cyc = 0;
    bit pix_hs = 0, b_pend = 0, b_hs = 0, aw_seen = 0, err_chk = 0;
    bit rdy_late = 0, aw_early = 0, aw_bad = 0;
    logic [31:0] aw_hold = '0;
    logic [31:0] aw_addr [2];
    aw_addr[0] = '0;
    aw_addr[1] = '0;
    pixel_valid = 1'b0;
    awready = 1'b0;
    wready = 1'b0;
    bvalid = 1'b0;
    bresp = 2'b00;
    while (cyc < 3000 && tail < 5) begin
      @(negedge clk);
      if (err_chk) begin
        check("bresp_err_set", 32'(bresp_err), 32'd1);
        err_chk = 0;
      end
      if (awvalid) begin
        if (!aw_seen) begin
          aw_seen = 1;
          aw_hold = awaddr;
          if (sent < BL * (aw_n + 1)) aw_early = 1;
        end else if (awaddr !== aw_hold) aw_bad = 1;
        awready = (aw_wait >= aw_delay);
        aw_wait++;
        if (awready) begin
          if (aw_n < 2) aw_addr[aw_n] = awaddr;
          aw_n++;
          aw_seen = 0;
          aw_wait = 0;
        end
      end else begin
        if (aw_seen) aw_bad = 1;
        awready = 1'b0;
      end
      if (pix_hs) begin
        pixel_valid = 1'b0;
        pix_hs = 0;
      end
      if (!pixel_valid && sent < offer && cyc >= next_cyc) begin
        pixel_valid = 1'b1;
        pixel_data  = 32'(sent);
      end
      if (pixel_ready && sent >= FW) rdy_late = 1;
      if (pixel_valid && pixel_ready) begin
        pix_hs = 1;
        sent++;
        next_cyc = cyc + gap;
      end
      if (b_hs) begin
        bvalid = 1'b0;
        b_hs = 0;
      end
      if (b_pend && !bvalid) begin
        bvalid = 1'b1;
        bresp  = (b_n == err_burst) ? 2'b10 : 2'b00;
        b_pend = 0;
      end
      if (bvalid && bready) begin
        b_hs = 1;
        if (bresp != 2'b00) err_chk = 1;
        b_n++;
        last_b_cyc = cyc;
      end
      wready = w_toggle ? (cyc % 2 == 1) : 1'b1;
      if (wvalid && wready) begin
        check("wdata", wdata, 32'(w_n));
        check("wlast", 32'(wlast), 32'((w_n % BL) == BL - 1));
        w_n++;
        if (wlast) b_pend = 1;
      end
      if (frame_done) begin
        dn++;
        done_cyc = cyc;
      end
      if (dn > 0) tail++;
      cyc++;
    end
    pixel_valid = 1'b0;
    awready = 1'b0;
    bvalid = 1'b0;
    check("aw_count", 32'(aw_n), 32'd2);
    check("awaddr0", aw_addr[0], base);
    check("awaddr1", aw_addr[1], base + 32'h40);
    check("w_count", 32'(w_n), 32'(FW));
    check("accepted", 32'(sent), 32'(FW));
    check("done_count", 32'(dn), 32'd1);
    check("done_latency", 32'(done_cyc - last_b_cyc), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("aw_stable", 32'(aw_bad), 32'd0);
    check("aw_early", 32'(aw_early), 32'd0);
    check("ready_after_last", 32'(rdy_late), 32'd0);
    check("bresp_err_end", 32'(bresp_err), 32'(err_burst >= 0));
  endtask

  initial begin
    int k;
    total = 0;
    bad = 0;
    rst = 1'b1;
    start_frame = 1'b0;
    base_addr = '0;
    pixel_data = '0;
    pixel_valid = 1'b0;
    awready = 1'b0;
    wready = 1'b0;
    bid = '0;
    bresp = 2'b00;
    buser = '0;
    bvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({awvalid, wvalid, bready, pixel_ready, busy, frame_done, bresp_err}), 32'd0);
    check("awlen", 32'(awlen), 32'd15);
    check("awsize", 32'(awsize), 32'd2);
    check("awburst", 32'(awburst), 32'd1);
    check("awcache", 32'(awcache), 32'd3);
    check("aw_misc", 32'({awid, awlock, awprot, awqos, awuser, wuser}), 32'd0);
    check("wstrb", 32'(wstrb), 32'hF);
    @(negedge clk);
    rst = 1'b0;

    // Basic frame, everything ready; more words offered than the frame holds.
    start_pulse(32'h0010_8000);
    run_frame(32'h0010_8000, 1, 0, 1'b0, -1, 40);

    // Slow AWREADY and WREADY toggling.
    start_pulse(32'h0010_8000);
    run_frame(32'h0010_8000, 1, 5, 1'b1, -1, 40);

    // Trickled pixels, one every four cycles; base near top of address space.
    start_pulse(32'hFFFF_FFC0);
    run_frame(32'hFFFF_FFC0, 4, 0, 1'b0, -1, 36);

    // SLVERR on burst 0; the frame still completes and a new start clears the flag.
    start_pulse(32'h0010_8000);
    run_frame(32'h0010_8000, 1, 0, 1'b0, 0, 32);
    start_pulse(32'h0040_0000);
    check("bresp_err_clear", 32'(bresp_err), 32'd0);
    run_frame(32'h0040_0000, 1, 0, 1'b0, -1, 32);

    // Ignored mid-frame start, then reset during the data phase.
    start_pulse(32'h0020_0000);
    awready = 1'b0;
    wready = 1'b1;
    k = 0;
    repeat (20) begin
      @(negedge clk);
      pixel_valid = 1'b1;
      pixel_data = 32'(k);
      if (pixel_ready) k++;
    end
    @(negedge clk);
    pixel_valid = 1'b0;
    check("rst_awvalid_pre", 32'(awvalid), 32'd1);
    base_addr = 32'h0030_0000;
    start_frame = 1'b1;
    @(negedge clk);
    start_frame = 1'b0;
    check("start_ignored_busy", 32'(busy), 32'd1);
    check("start_ignored_addr", awaddr, 32'h0020_0000);
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    check("rst_in_data", 32'(wvalid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_outputs", 32'({awvalid, wvalid, bready, pixel_ready, busy, frame_done}), 32'd0);
    rst = 1'b0;

    // Clean frame after the abandoned one.
    start_pulse(32'h0010_8000);
    run_frame(32'h0010_8000, 1, 0, 1'b0, -1, 32);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/framewriter.md
FRAMEWRITER -- requirements
Module: framewriter

Interface
REQ-001 SHALL have parameter C_M_AXI_BURST_LEN, 16, beats per write burst (power of two, 2..256).
REQ-002 SHALL have parameter C_M_AXI_ID_WIDTH, 1, AXI ID width.
REQ-003 SHALL have parameter C_M_AXI_ADDR_WIDTH, 32, AXI address width.
REQ-004 SHALL have parameter C_M_AXI_DATA_WIDTH, 32, AXI data width, also the pixel word width (two RGB565 pixels).
REQ-005 SHALL have parameters C_M_AXI_AWUSER_WIDTH, C_M_AXI_WUSER_WIDTH and C_M_AXI_BUSER_WIDTH, 0 each, user widths.
REQ-006 SHALL have parameter FRAME_WORDS, 153600, words per frame (640x480x16bpp/32); an integer multiple of C_M_AXI_BURST_LEN.
REQ-007 SHALL have ports M_AXI_ACLK input 1, sole clock; M_AXI_ARESET input 1, synchronous active-high reset.
REQ-008 SHALL have ports start_frame input 1, one-cycle frame start pulse; base_addr input ADDR_WIDTH, framebuffer base, sampled on an accepted start.
REQ-009 SHALL have ports pixel_data input DATA_WIDTH, pixel_valid input 1, pixel_ready output 1: valid/ready pixel-word stream.
REQ-010 SHALL have ports busy output 1, frame in progress; frame_done output 1, one-cycle pulse; bresp_err output 1, sticky error flag.
REQ-011 SHALL have AXI4 write-master ports M_AXI_AW{ID,ADDR,LEN,SIZE,BURST,LOCK,CACHE,PROT,QOS,USER,VALID} output, AWREADY input; M_AXI_W{DATA,STRB,LAST,USER,VALID} output, WREADY input; M_AXI_B{ID,RESP,USER,VALID} input, BREADY output, AXI4-standard widths.

Function
REQ-012 SHALL drive AWID=0, AWLEN=BURST_LEN-1, AWSIZE=log2(DATA_WIDTH/8), AWBURST=INCR, AWLOCK=0, AWCACHE=4'b0011, AWPROT=0, AWQOS=0, user outputs 0, WSTRB all ones.
REQ-013 SHALL accept start_frame only in IDLE; starts while busy SHALL be ignored.
REQ-014 SHALL buffer accepted words in a FIFO of depth 2*BURST_LEN; pixel_ready = busy AND FIFO not full AND words accepted < FRAME_WORDS.
REQ-015 SHALL implement states IDLE, WAIT_DATA, ADDR, DATA, RESP.
REQ-016 IDLE->WAIT_DATA on accepted start; WAIT_DATA->ADDR when FIFO count >= BURST_LEN; ADDR->DATA on AWVALID&&AWREADY; DATA->RESP on WVALID&&WREADY&&WLAST; RESP->WAIT_DATA on BVALID&&BREADY unless the last burst, then ->IDLE.
REQ-017 AWVALID SHALL be high in ADDR only and held until AWREADY; AWADDR = base_addr + burst_index*BURST_LEN*(DATA_WIDTH/8), modulo 2^ADDR_WIDTH.
REQ-018 WVALID SHALL be high throughout DATA with WDATA = FIFO head; FIFO pops only on WVALID&&WREADY; WLAST high on beat BURST_LEN-1 only.
REQ-019 BREADY SHALL be high in RESP only; exactly one burst outstanding at any time.
REQ-020 BRESP != OKAY SHALL set bresp_err, held until reset or the next accepted start; the frame SHALL still complete.
REQ-021 frame_done SHALL pulse the cycle after the final B handshake; busy SHALL be low in IDLE only.
REQ-022 Simultaneous FIFO push and pop SHALL leave the count unchanged; full/empty SHALL derive from registered count only.
REQ-023 Pixel words SHALL reach WDATA in acceptance order without loss or duplication; words beyond FRAME_WORDS are never accepted.

Reset
REQ-024 On M_AXI_ARESET SHALL go to IDLE, clear FIFO, counters and bresp_err, and drive all valids, BREADY, pixel_ready, busy and frame_done low on the next edge.
REQ-025 Reset mid-burst SHALL abandon the transaction; no recovery of partial bursts is required.

Structure
REQ-026 Package framewriter_pkg SHALL hold the state enum and the AXI_BURST_INCR, AXI_RESP_OKAY and AWCACHE constants.
REQ-027 The FIFO SHALL be a sub-module, pixel_fifo (parameterised width/depth, registered count).

Verification
REQ-028 BURST_LEN=16, FRAME_WORDS=32, base 0x0010_8000, streaming 0..31 with AW/W/B always ready -> AWADDR 0x0010_8000 then 0x0010_8040, WDATA 0..31, WLAST on beats 15 and 31, one frame_done.
REQ-029 Same frame, AWREADY delayed 5 cycles and WREADY toggling every cycle -> AWVALID held stable, data order intact, 32 W handshakes total.
REQ-030 Pixels trickled one per 4 cycles -> AWVALID not asserted before the 16th word is buffered; pixel_ready low after word 31.
REQ-031 BRESP=SLVERR on burst 0 -> bresp_err high from that cycle, burst 1 still issued, frame_done pulses; next start clears bresp_err.
REQ-032 start_frame pulsed mid-frame, then reset asserted during DATA -> start ignored; next cycle all valids low and busy low.
